// File: rtl/npu_pool_pkg.sv
// == npu_pool_pkg : shared pooling mode codes, FSM state encoding and helpers ==
// == rev 1.0 ==
`default_nettype none

package npu_pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } pool_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_window_acc.sv
// == pool_window_acc : running max / sum over one pooling window ==
// == rev 1.0 ==
`default_nettype none

module pool_window_acc
  import npu_pool_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_WIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [3:0]               win_size,
  input  logic                     clear,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [DATA_W-1:0] result
);

  localparam int ACC_W = DATA_W + 2 * clog2(MAX_WIN);
  localparam logic signed [ACC_W-1:0] MAX_INIT =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [3:0]              shamt;

  assign data_ext = ACC_W'(data);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= (mode == POOL_AVG) ? '0 : MAX_INIT;
    end else if (valid) begin
      if (mode == POOL_AVG) acc <= acc + data_ext;
      else if (data_ext > acc) acc <= data_ext;  // strict: ties keep earlier
    end
  end

  // Average is only legal for K in {1,2,4}, so log2(K*K) is a small table
  always_comb begin
    shamt = 4'd0;
    case (win_size)
      4'd2:    shamt = 4'd2;
      4'd4:    shamt = 4'd4;
      default: shamt = 4'd0;
    endcase
  end

  assign shifted = acc >>> shamt;
  assign result  = (mode == POOL_AVG) ? shifted[DATA_W-1:0] : acc[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/matrix_pool_engine.sv
// == matrix_pool_engine : K x K / stride S max or average pooling over scratch RAM ==
// == rev 1.0 ==
`default_nettype none

module matrix_pool_engine
  import npu_pool_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 14,
  parameter int DIM_W   = 10,
  parameter int MAX_WIN = 4,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [3:0]        win_size,
  input  logic [3:0]        stride,
  input  logic [ADDR_W-1:0] src_start_address,
  input  logic [DIM_W-1:0]  src_rows,
  input  logic [DIM_W-1:0]  src_cols,
  input  logic [ADDR_W-1:0] dest_start_address,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  output logic [ADDR_W-1:0] dest_address,
  output logic [DATA_W-1:0] dest_writedata,
  output logic              dest_write_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [3:0]        MAX_K      = 4'(MAX_WIN);
  localparam logic [3:0]        DRAIN_LAST = 4'(RD_LAT - 1);
  localparam logic [DIM_W-1:0]  DIM_ONE    = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  pool_state_t state, state_nx;

  logic              mode_q;
  logic [3:0]        k_q, s_q;
  logic [ADDR_W-1:0] src_base_q;
  logic [DIM_W-1:0]  rows_q, cols_q;
  logic [DIM_W-1:0]  out_rows, out_cols, out_row, out_col;
  logic [3:0]        wr, wc, drain_cnt;
  logic [ADDR_W-1:0] win_base, row_base, line_base;
  logic [RD_LAT-1:0] vpipe;
  logic [ADDR_W-1:0] cols_ext, s_ext, s_step, next_row;
  logic [DATA_W-1:0] acc_result;
  logic              cfg_bad, last_tap, row_end, last_out, drain_end, acc_clear;

  assign cols_ext  = ADDR_W'(cols_q);
  assign s_ext     = ADDR_W'(s_q);
  assign s_step    = s_ext * cols_ext;
  assign next_row  = row_base + s_step;
  assign last_tap  = (wr == k_q - 4'd1) && (wc == k_q - 4'd1);
  assign row_end   = (out_col == out_cols - DIM_ONE);
  assign last_out  = row_end && (out_row == out_rows - DIM_ONE);
  assign drain_end = (drain_cnt == DRAIN_LAST);

  assign cfg_bad = (k_q == 4'd0) || (k_q > MAX_K) || (s_q == 4'd0) ||
                   (DIM_W'(k_q) > rows_q) || (DIM_W'(k_q) > cols_q) ||
                   ((mode_q == POOL_AVG) && !(k_q == 4'd1 || k_q == 4'd2 || k_q == 4'd4));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    busy           = 1'b1;
    done           = 1'b0;
    dest_write_en  = 1'b0;
    dest_writedata = '0;
    acc_clear      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nx = CHECK;
      end
      CHECK: begin
        acc_clear = 1'b1;
        state_nx  = cfg_bad ? IDLE : READ;
      end
      READ:  if (last_tap) state_nx = DRAIN;
      DRAIN: if (drain_end) state_nx = WRITE;
      WRITE: begin
        dest_write_en  = 1'b1;
        dest_writedata = acc_result;
        acc_clear      = 1'b1;
        state_nx       = last_out ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= 1'b0;
      k_q          <= '0;
      s_q          <= '0;
      src_base_q   <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      out_rows     <= '0;
      out_cols     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      wr           <= '0;
      wc           <= '0;
      drain_cnt    <= '0;
      win_base     <= '0;
      row_base     <= '0;
      line_base    <= '0;
      vpipe        <= '0;
      cfg_err      <= 1'b0;
      src_address  <= src_start_address;
      dest_address <= dest_start_address;
    end else begin
      vpipe[0] <= (state == READ);
      for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
      case (state)
        IDLE: if (start) begin
          mode_q       <= mode;
          k_q          <= win_size;
          s_q          <= stride;
          src_base_q   <= src_start_address;
          rows_q       <= src_rows;
          cols_q       <= src_cols;
          dest_address <= dest_start_address;
          cfg_err      <= 1'b0;
        end
        CHECK: begin
          if (cfg_bad) begin
            cfg_err <= 1'b1;
          end else begin
            out_rows    <= (rows_q - DIM_W'(k_q)) / DIM_W'(s_q) + DIM_ONE;
            out_cols    <= (cols_q - DIM_W'(k_q)) / DIM_W'(s_q) + DIM_ONE;
            out_row     <= '0;
            out_col     <= '0;
            wr          <= '0;
            wc          <= '0;
            win_base    <= src_base_q;
            row_base    <= src_base_q;
            line_base   <= src_base_q;
            src_address <= src_base_q;
          end
        end
        READ: begin
          drain_cnt <= '0;
          if (!last_tap) begin
            if (wc == k_q - 4'd1) begin
              wc          <= '0;
              wr          <= wr + 4'd1;
              line_base   <= line_base + cols_ext;
              src_address <= line_base + cols_ext;
            end else begin
              wc          <= wc + 4'd1;
              src_address <= src_address + ADDR_ONE;
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 4'd1;
        WRITE: begin
          dest_address <= dest_address + ADDR_ONE;
          wr           <= '0;
          wc           <= '0;
          // src_address only moves when another window follows
          if (!last_out) begin
            if (row_end) begin
              out_col     <= '0;
              out_row     <= out_row + DIM_ONE;
              row_base    <= next_row;
              win_base    <= next_row;
              line_base   <= next_row;
              src_address <= next_row;
            end else begin
              out_col     <= out_col + DIM_ONE;
              win_base    <= win_base + s_ext;
              line_base   <= win_base + s_ext;
              src_address <= win_base + s_ext;
            end
          end
        end
        default: ;
      endcase
    end
  end

  pool_window_acc #(
    .DATA_W  (DATA_W),
    .MAX_WIN (MAX_WIN)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode_q),
    .win_size (k_q),
    .clear    (acc_clear),
    .valid    (vpipe[RD_LAT-1]),
    .data     (src_readdata),
    .result   (acc_result)
  );

endmodule

`default_nettype wire

// File: tb/tb_matrix_pool_engine.sv
// == tb_matrix_pool_engine : vector table + write scoreboard for the pooling engine ==
// == rev 1.0 ==
`default_nettype none
`timescale 1ns/1ps

module tb_matrix_pool_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int DIM_W  = 10;
  localparam int LIMIT  = 5000;

  typedef struct {
    bit mode;
    int k, s, r, c, src, dst;
    bit exp_err;
    bit restart;
    bit chk_src;
  } vec_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [3:0]        win_size = '0;
  logic [3:0]        stride = '0;
  logic [ADDR_W-1:0] src_start_address = '0;
  logic [DIM_W-1:0]  src_rows = '0;
  logic [DIM_W-1:0]  src_cols = '0;
  logic [ADDR_W-1:0] dest_start_address = '0;
  logic [ADDR_W-1:0] src_address;
  logic [DATA_W-1:0] src_readdata;
  logic [ADDR_W-1:0] dest_address;
  logic [DATA_W-1:0] dest_writedata;
  logic              dest_write_en, busy, done, cfg_err;

  logic signed [15:0] mem [0:16383];
  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  max_src = 0;

  matrix_pool_engine dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .mode               (mode),
    .win_size           (win_size),
    .stride             (stride),
    .src_start_address  (src_start_address),
    .src_rows           (src_rows),
    .src_cols           (src_cols),
    .dest_start_address (dest_start_address),
    .src_address        (src_address),
    .src_readdata       (src_readdata),
    .dest_address       (dest_address),
    .dest_writedata     (dest_writedata),
    .dest_write_en      (dest_write_en),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_readdata <= mem[src_address];

  task automatic check(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask

  // Write scoreboard and source-address watermark
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (busy && int'(src_address) > max_src) max_src = int'(src_address);
      if (dest_write_en) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0h data=%0d", dest_address, $signed(dest_writedata));
        end else begin
          w = exp_q.pop_front();
          if (dest_address !== ADDR_W'(w.addr) || dest_writedata !== DATA_W'(w.data)) begin
            bad++;
            $display("FAIL write got addr=%0h data=%0d need addr=%0h data=%0d",
                     dest_address, $signed(dest_writedata), w.addr, w.data);
          end
        end
      end
    end
  end

  function automatic int fdiv(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic vec_t mk(input bit m, input int k, input int s, input int r, input int c,
                              input int src, input int dst, input bit err, input bit rs, input bit cs);
    vec_t v;
    v.mode = m; v.k = k; v.s = s; v.r = r; v.c = c; v.src = src; v.dst = dst;
    v.exp_err = err; v.restart = rs; v.chk_src = cs;
    return v;
  endfunction

  task automatic push_expected(input vec_t v);
    int orows, ocols, idx, acc, a, d;
    wr_t w;
    orows = (v.r - v.k) / v.s + 1;
    ocols = (v.c - v.k) / v.s + 1;
    idx = 0;
    for (int orr = 0; orr < orows; orr++) begin
      for (int occ = 0; occ < ocols; occ++) begin
        acc = v.mode ? 0 : -32768;
        for (int i = 0; i < v.k; i++) begin
          for (int j = 0; j < v.k; j++) begin
            a = (v.src + (orr * v.s + i) * v.c + occ * v.s + j) & 'h3fff;
            d = int'(mem[a]);
            if (v.mode) acc += d;
            else if (d > acc) acc = d;
          end
        end
        if (v.mode) acc = fdiv(acc, v.k * v.k);
        w.addr = (v.dst + idx) & 'h3fff;
        w.data = acc;
        exp_q.push_back(w);
        idx++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, exp_busy, orows, ocols;
    if (v.exp_err) begin
      exp_busy = 1;
    end else begin
      orows = (v.r - v.k) / v.s + 1;
      ocols = (v.c - v.k) / v.s + 1;
      exp_busy = 1 + orows * ocols * (v.k * v.k + 2);
      push_expected(v);
    end
    @(negedge clk);
    max_src            = 0;
    mode               = v.mode;
    win_size           = 4'(v.k);
    stride             = 4'(v.s);
    src_rows           = DIM_W'(v.r);
    src_cols           = DIM_W'(v.c);
    src_start_address  = ADDR_W'(v.src);
    dest_start_address = ADDR_W'(v.dst);
    start              = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_cleared_on_start", int'(cfg_err), 0);
    mode               = 1'($urandom);
    win_size           = 4'($urandom);
    stride             = 4'($urandom);
    src_rows           = DIM_W'($urandom);
    src_cols           = DIM_W'($urandom);
    src_start_address  = ADDR_W'($urandom);
    dest_start_address = ADDR_W'($urandom);
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      start = v.restart && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("busy_cycles", cyc, exp_busy);
    check("done_after_run", int'(done), 1);
    check("cfg_err_after_run", int'(cfg_err), int'(v.exp_err));
    check("writes_missing", exp_q.size(), 0);
    if (v.chk_src)
      check("src_addr_max", max_src,
            v.src + ((v.r - v.k) / v.s) * v.s * v.c + (v.k - 1) * v.c +
            ((v.c - v.k) / v.s) * v.s + v.k - 1);
    if (v.exp_err) begin
      repeat (3) @(negedge clk);
      check("cfg_err_held", int'(cfg_err), 1);
    end
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[14];

    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem['h100 + i] = 16'(i);
    for (int i = 0; i < 25; i++) mem['h200 + i] = -16'sd7;
    mem['h200 + 12] = -16'sd1;
    for (int i = 0; i < 25; i++) mem['h300 + i] = 16'h8000;
    for (int i = 0; i < 20; i++) mem['h400 + i] = 16'($urandom);

    vecs[0]  = mk(0, 2, 2, 4, 4, 'h100, 'h1000, 0, 1, 0);
    vecs[1]  = mk(1, 2, 2, 4, 4, 'h100, 'h1010, 0, 0, 0);
    vecs[2]  = mk(0, 3, 1, 5, 5, 'h200, 'h1020, 0, 0, 0);
    vecs[3]  = mk(0, 3, 1, 5, 5, 'h300, 'h1030, 0, 0, 0);
    vecs[4]  = mk(1, 3, 1, 4, 4, 'h100, 'h1100, 1, 0, 0);
    vecs[5]  = mk(0, 5, 1, 4, 4, 'h100, 'h1100, 1, 0, 0);
    vecs[6]  = mk(0, 4, 1, 3, 4, 'h100, 'h1100, 1, 0, 0);
    vecs[7]  = mk(0, 3, 1, 5, 2, 'h200, 'h1100, 1, 0, 0);
    vecs[8]  = mk(0, 2, 0, 4, 4, 'h100, 'h1100, 1, 0, 0);
    vecs[9]  = mk(0, 2, 2, 5, 4, 'h400, 'h1040, 0, 0, 1);
    vecs[10] = mk(1, 4, 1, 5, 4, 'h400, 'h1050, 0, 0, 0);
    vecs[11] = mk(1, 1, 1, 4, 4, 'h100, 'h1060, 0, 0, 0);
    vecs[12] = mk(0, 2, 3, 5, 5, 'h200, 'h1070, 0, 0, 0);
    vecs[13] = mk(1, 4, 2, 4, 4, 'h100, 'h1080, 0, 0, 0);

    src_start_address  = 14'h123;
    dest_start_address = 14'h456;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 1);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_write_en", int'(dest_write_en), 0);
    check("rst_src_addr", int'(src_address), 'h123);
    check("rst_dest_addr", int'(dest_address), 'h456);
    check("rst_writedata", int'(dest_writedata), 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset while the first window is being read
    @(negedge clk);
    mode = 1'b0; win_size = 4'd2; stride = 4'd2;
    src_rows = 10'd4; src_cols = 10'd4;
    src_start_address = 14'h100; dest_start_address = 14'h1200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before_reset", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_write_en", int'(dest_write_en), 0);
    check("midrun_rst_busy", int'(busy), 0);
    check("midrun_rst_done", int'(done), 1);
    check("midrun_rst_src_addr", int'(src_address), 'h100);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrun_stays_idle", int'(busy), 0);

    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
